// File: rtl/esdi_pkg.sv
// esdi_pkg -- shared types and helpers for the ESDI serial command engine.
//   esdi_state_t : sequencing states of the engine
//   ESDI_WORD_W  : command/status word width
//   ESDI_FRAME_W : serial frame width (word plus one parity bit)
//   odd_parity() : parity bit that makes a word plus that bit hold an odd count of ones
package esdi_pkg;

  localparam int ESDI_WORD_W  = 16;
  localparam int ESDI_FRAME_W = 17;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD_SETUP = 3'd1,
    CMD_REQ   = 3'd2,
    CMD_REL   = 3'd3,
    RSP_REQ   = 3'd4,
    RSP_REL   = 3'd5,
    WAIT_CC   = 3'd6,
    FINISH    = 3'd7
  } esdi_state_t;

  function automatic logic odd_parity(input logic [ESDI_WORD_W-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/esdi_sync.sv
// esdi_sync -- W-bit two-flop synchronizer for asynchronous ESDI pins.
//   clk, rst : block clock, asynchronous active-high reset (flops clear to 0)
//   d        : asynchronous inputs
//   q        : synchronized outputs, two clk cycles behind d
module esdi_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/esdi_serial_engine.sv
// esdi_serial_engine -- ESDI serial command/status handshake engine.
// Shifts a 17-bit command frame (word + odd parity) out on esdi_command_data
// with a REQ/ACK handshake per bit, reads back up to MAX_RSP 17-bit status
// frames from esdi_confstat_data, then waits for command complete.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid/ready/word/rsp_cnt : host command interface
//   rsp_valid/word/perr      : received status word (one-cycle pulse)
//   done                     : end-of-sequence pulse (also on timeout)
//   err_timeout              : sticky timeout flag, cleared on next command
//   attention                : synchronized esdi_attention
//   esdi_*                   : ESDI serial interface pins
// Optional feature: define ESDI_PARITY_CHECK_EN to check status-frame parity
// (rsp_perr); otherwise rsp_perr is 0 and the parity bit is dropped.
module esdi_serial_engine
  import esdi_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RSP     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ESDI_WORD_W-1:0] cmd_word,
  input  logic [2:0]             cmd_rsp_cnt,
  output logic                   rsp_valid,
  output logic [ESDI_WORD_W-1:0] rsp_word,
  output logic                   rsp_perr,
  output logic                   done,
  output logic                   err_timeout,
  output logic                   attention,
  output logic                   esdi_transfer_req,
  output logic                   esdi_command_data,
  input  logic                   esdi_transfer_ack,
  input  logic                   esdi_confstat_data,
  input  logic                   esdi_command_complete,
  input  logic                   esdi_attention
);

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  MAX_RSP_V = 3'(MAX_RSP);

  esdi_state_t state, next_state;
  logic [3:0]  sync_q;
  logic        ack_s, cs_s, cc_s;
  logic [7:0]  div_cnt;
  logic [31:0] tmo_cnt;
  logic [4:0]  bit_cnt, rbit_cnt;
  logic [2:0]  rsp_left;
  logic [ESDI_FRAME_W-1:0] cmd_shift;
  logic [ESDI_WORD_W-1:0]  rsp_shift;
  logic        ack_armed, accept, in_wait, tmo_hit, hs_rise, word_done;
  logic        abort, perr_calc, req_d, done_d, ready_d;

  esdi_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({esdi_attention, esdi_command_complete, esdi_confstat_data, esdi_transfer_ack}),
    .q   (sync_q)
  );

  assign ack_s     = sync_q[0];
  assign cs_s      = sync_q[1];
  assign cc_s      = sync_q[2];
  assign attention = sync_q[3];

  assign esdi_command_data = cmd_shift[ESDI_FRAME_W-1];
  assign accept    = cmd_valid && cmd_ready;
  assign in_wait   = (state inside {CMD_REQ, CMD_REL, RSP_REQ, RSP_REL, WAIT_CC});
  assign tmo_hit   = in_wait && (tmo_cnt == TMO_LAST);
  // A handshake needs REQ up and an ACK that was seen low since the last one,
  // so a stuck-high ACK cannot complete a bit and ends in the timeout.
  assign hs_rise   = esdi_transfer_req && ack_s && ack_armed;
  assign word_done = (state == RSP_REL) && !ack_s && (rbit_cnt == 5'd17);

`ifdef ESDI_PARITY_CHECK_EN
  logic rsp_par;
  // Holds the received parity bit of the status frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_par <= 1'b0;
    end else if ((state == RSP_REQ) && hs_rise && (rbit_cnt == 5'd16)) begin
      rsp_par <= cs_s;
    end else begin
      rsp_par <= rsp_par;
    end
  end
  assign perr_calc = (odd_parity(rsp_shift) != rsp_par);
`else
  assign perr_calc = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a successful handshake wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = CMD_SETUP;
        else        next_state = IDLE;
      end
      CMD_SETUP: begin
        if (div_cnt == DIV_LAST) next_state = CMD_REQ;
        else                     next_state = CMD_SETUP;
      end
      CMD_REQ: begin
        if (hs_rise)      next_state = CMD_REL;
        else if (tmo_hit) begin next_state = FINISH; abort = 1'b1; end
        else              next_state = CMD_REQ;
      end
      CMD_REL: begin
        if (!ack_s) begin
          if (bit_cnt == 5'd16) next_state = (rsp_left != 3'd0) ? RSP_REQ : WAIT_CC;
          else                  next_state = CMD_SETUP;
        end else if (tmo_hit) begin
          next_state = FINISH; abort = 1'b1;
        end else begin
          next_state = CMD_REL;
        end
      end
      RSP_REQ: begin
        if (hs_rise)      next_state = RSP_REL;
        else if (tmo_hit) begin next_state = FINISH; abort = 1'b1; end
        else              next_state = RSP_REQ;
      end
      RSP_REL: begin
        if (!ack_s) begin
          if ((rbit_cnt == 5'd17) && (rsp_left == 3'd1)) next_state = WAIT_CC;
          else                                           next_state = RSP_REQ;
        end else if (tmo_hit) begin
          next_state = FINISH; abort = 1'b1;
        end else begin
          next_state = RSP_REL;
        end
      end
      WAIT_CC: begin
        if (cc_s)         next_state = FINISH;
        else if (tmo_hit) begin next_state = FINISH; abort = 1'b1; end
        else              next_state = WAIT_CC;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the pins change on state entry.
  always_comb begin
    req_d   = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (next_state)
      IDLE:    ready_d = 1'b1;
      CMD_REQ: req_d   = 1'b1;
      // Status REQ rises only after CLK_DIV cycles in RSP_REQ, then holds.
      RSP_REQ: req_d   = (state == RSP_REQ) && (esdi_transfer_req || (div_cnt == DIV_LAST));
      FINISH:  done_d  = 1'b1;
      default: req_d   = 1'b0;
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esdi_transfer_req <= 1'b0;
      done              <= 1'b0;
      cmd_ready         <= 1'b1;
    end else begin
      esdi_transfer_req <= req_d;
      done              <= done_d;
      cmd_ready         <= ready_d;
    end
  end

  // Counters, shift registers and response bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= 8'd0;
      tmo_cnt     <= 32'd0;
      ack_armed   <= 1'b0;
      cmd_shift   <= '0;
      bit_cnt     <= 5'd0;
      rbit_cnt    <= 5'd0;
      rsp_left    <= 3'd0;
      rsp_shift   <= '0;
      rsp_valid   <= 1'b0;
      rsp_word    <= '0;
      rsp_perr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (next_state != state)  div_cnt <= 8'd0;
      else if (div_cnt != 8'hFF) div_cnt <= div_cnt + 8'd1;

      if ((next_state != state) || !in_wait) tmo_cnt <= 32'd0;
      else                                   tmo_cnt <= tmo_cnt + 32'd1;

      if (!ack_s)       ack_armed <= 1'b1;
      else if (hs_rise) ack_armed <= 1'b0;

      rsp_valid <= 1'b0;

      if (accept) begin
        cmd_shift   <= {cmd_word, odd_parity(cmd_word)};
        rsp_left    <= (cmd_rsp_cnt > MAX_RSP_V) ? MAX_RSP_V : cmd_rsp_cnt;
        bit_cnt     <= 5'd0;
        rbit_cnt    <= 5'd0;
        err_timeout <= 1'b0;
      end

      // Zero is shifted in, so the data pin idles low after the last bit.
      if ((state == CMD_REL) && !ack_s) begin
        cmd_shift <= {cmd_shift[ESDI_FRAME_W-2:0], 1'b0};
        bit_cnt   <= bit_cnt + 5'd1;
      end

      if ((state == RSP_REQ) && hs_rise) begin
        if (rbit_cnt < 5'd16) rsp_shift <= {rsp_shift[ESDI_WORD_W-2:0], cs_s};
        rbit_cnt <= rbit_cnt + 5'd1;
      end

      if (word_done) begin
        rsp_valid <= 1'b1;
        rsp_word  <= rsp_shift;
        rsp_perr  <= perr_calc;
        rsp_left  <= rsp_left - 3'd1;
        rbit_cnt  <= 5'd0;
      end

      if (abort) begin
        err_timeout <= 1'b1;
        cmd_shift   <= '0;
      end
    end
  end

endmodule

// File: doc/esdi_serial_engine.md
ESDI_SERIAL_ENGINE -- requirements
Module: esdi_serial_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the minimum clk cycles between a pin change and the next REQ edge; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, meaning the clk cycles allowed per ACK or COMMAND COMPLETE wait before abort.
REQ-003 SHALL have parameter MAX_RSP, default 4, meaning the maximum status words per command; legal range 1..7.
REQ-004 clk  in  1  single block clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  in  1  host command offered.
REQ-007 cmd_ready  out  1  engine idle and accepting a command.
REQ-008 cmd_word  in  16  ESDI command word.
REQ-009 cmd_rsp_cnt  in  3  number of status words to read back after the command; 0..MAX_RSP.
REQ-010 rsp_valid  out  1  one-cycle pulse: a status word is complete.
REQ-011 rsp_word  out  16  received status word.
REQ-012 rsp_perr  out  1  parity error on rsp_word; qualified by rsp_valid.
REQ-013 done  out  1  one-cycle pulse: command sequence finished.
REQ-014 err_timeout  out  1  sticky; cleared by the next accepted command.
REQ-015 attention  out  1  synchronized esdi_attention.
REQ-016 esdi_transfer_req / esdi_command_data  out  1 each  ESDI pins; esdi_transfer_ack, esdi_confstat_data, esdi_command_complete, esdi_attention  in  1 each  ESDI pins.

Function
REQ-017 All four ESDI inputs SHALL pass through 2-flop synchronizers before use, which adds 2 cycles of latency.
REQ-018 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_word and cmd_rsp_cnt SHALL be latched; a cmd_rsp_cnt greater than MAX_RSP SHALL be clamped to MAX_RSP.
REQ-019 The command frame SHALL be 17 bits, MSB first: cmd_word[15:0] followed by an odd-parity bit over those 16 bits.
REQ-020 FSM states SHALL be IDLE, CMD_SETUP, CMD_REQ, CMD_REL, RSP_REQ, RSP_REL, WAIT_CC, FINISH.
REQ-021 CMD_SETUP: drive esdi_command_data with the current bit, hold for CLK_DIV cycles, then go to CMD_REQ.
REQ-022 CMD_REQ: assert esdi_transfer_req and wait for synchronized ACK high, then go to CMD_REL.
REQ-023 CMD_REL: deassert REQ and wait for ACK low; then go to CMD_SETUP for the next bit, or, after bit 16, go to RSP_REQ if any responses remain, else go to WAIT_CC.
REQ-024 RSP_REQ: assert REQ after a CLK_DIV gap and wait for ACK high; then sample esdi_confstat_data (synchronized) into a 17-bit shift register, MSB first, and go to RSP_REL.
REQ-025 RSP_REL: deassert REQ and wait for ACK low; after the 17th bit, pulse rsp_valid with rsp_word = bits 16..1 and decrement the word count; go to RSP_REQ while words remain, else go to WAIT_CC.
REQ-026 WAIT_CC: wait for synchronized esdi_command_complete high, then go to FINISH.
REQ-027 FINISH: pulse done for one cycle and return to IDLE.
REQ-028 cmd_ready SHALL be high only in IDLE.
REQ-029 Each wait state SHALL run a counter that is reset on every state entry; reaching TIMEOUT_CYC SHALL deassert REQ, set err_timeout, pulse done, and return to IDLE.
REQ-030 A cmd_valid presented while the engine is busy SHALL be ignored, and no pin activity SHALL change.
REQ-031 An ACK that is already high on entry to CMD_REQ or RSP_REQ SHALL count as a handshake only after it has been observed low in the preceding REL state; a protocol violation SHALL be handled by the timeout.
REQ-032 attention SHALL be informational only and SHALL NOT abort a sequence in progress.

Reset
REQ-033 While rst is high: FSM in IDLE; esdi_transfer_req=0, esdi_command_data=0, cmd_ready=1 after release, rsp_valid=0, rsp_word=0, rsp_perr=0, done=0, err_timeout=0, synchronizers=0, counters=0.
REQ-034 Reset asserted mid-sequence SHALL drop REQ within the same cycle, asynchronously, with no done pulse.

Configuration
REQ-035 With ESDI_PARITY_CHECK_EN defined, rsp_perr SHALL equal NOT(odd parity across all 17 received bits holds).
REQ-036 Without ESDI_PARITY_CHECK_EN, rsp_perr SHALL be tied to 0 and bit 0 of the frame SHALL be discarded.

Structure
REQ-037 Package esdi_pkg SHALL hold the FSM state enum, ESDI_WORD_W=16, ESDI_FRAME_W=17, and an odd-parity function.
REQ-038 Sub-module esdi_sync SHALL be a parameterizable-width 2-flop synchronizer, instantiated once for the 4 inputs.

Verification
REQ-039 cmd_word=16'h0000, rsp_cnt=0, drive model ACKs after 3 cycles -> 17 REQ pulses with data 0 x16 then parity 1; done pulses once after command_complete goes high.
REQ-040 cmd_word=16'h1234, rsp_cnt=2, drive returns 16'hA5A5 and 16'h00FF with correct parity -> two rsp_valid pulses with those words and rsp_perr=0.
REQ-041 Drive returns 16'hA5A5 with the parity bit flipped -> rsp_perr=1 when ESDI_PARITY_CHECK_EN is defined, 0 otherwise.
REQ-042 Drive never ACKs bit 5, TIMEOUT_CYC=50 -> REQ low, err_timeout=1, and done pulse 50 cycles after REQ rose; the next command clears err_timeout.
REQ-043 rst asserted during RSP_REQ -> REQ and outputs reach reset values immediately; a fresh command afterward completes normally.
REQ-044 cmd_valid held high through a busy command -> exactly one command is accepted, and a second is accepted only on the cycle after done.
